muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit_if.sv | 23 ++
 rtl/muldiv_unit.sv | 180 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// Operand/result bundle between the register file, the muldiv_unit and the write-back stage.
interface muldiv_unit_if;
  logic        start;
  logic [2:0]  funct3;
  logic        op_word;
  logic [63:0] rs1_data;
  logic [63:0] rs2_data;
  logic [4:0]  rd_address;
  logic        busy;
  logic        done;
  logic [63:0] result;
  logic [4:0]  rd_out;

  modport master (
    output start, funct3, op_word, rs1_data, rs2_data, rd_address,
    input  busy, done, result, rd_out
  );

  modport slave (
    input  start, funct3, op_word, rs1_data, rs2_data, rd_address,
    output busy, done, result, rd_out
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide: shift-add multiply, restoring divide, 67-cycle occupancy.
// Define MULDIV_WORD_OPS_EN to enable the 32-bit *W instruction variants.
module muldiv_unit (
  input  logic         clock,
  input  logic         reset,
  muldiv_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, PREP, CALC, FIN} state_t;

  state_t       state_q, state_d;
  logic [5:0]   cnt_q, cnt_d;
  logic [63:0]  a_q, a_d, b_q, b_d;
  logic [127:0] acc_q, acc_d;
  logic [2:0]   funct3_q, funct3_d;
  logic         word_q, word_d;
  logic [4:0]   rd_q, rd_d;
  logic         neg_a_q, neg_a_d, neg_b_q, neg_b_d;
  logic         div_zero_q, div_zero_d;
  logic         busy_q, busy_d, done_q, done_d;
  logic [63:0]  result_q, result_d;
  logic [4:0]   rd_out_q, rd_out_d;

  logic         word_in;
  logic         is_div, signed_a, signed_b, mul_high;
  logic [63:0]  ext_a, ext_b, mag_a, mag_b, quo, rem, res;
  logic [127:0] prod;
  logic [64:0]  mul_sum, div_shift, div_diff;

`ifdef MULDIV_WORD_OPS_EN
  assign word_in = bus.op_word;
`else
  logic unused_op_word;
  assign unused_op_word = bus.op_word;
  assign word_in = 1'b0;
`endif

  always_comb begin
    is_div = funct3_q[2];
    if (word_q) begin
      // Every *W multiply returns only the low word, so operand signedness is irrelevant there
      signed_a = is_div & ~funct3_q[0];
      signed_b = signed_a;
      mul_high = 1'b0;
      ext_a    = signed_a ? {{32{a_q[31]}}, a_q[31:0]} : {32'd0, a_q[31:0]};
      ext_b    = signed_b ? {{32{b_q[31]}}, b_q[31:0]} : {32'd0, b_q[31:0]};
    end else begin
      signed_a = (funct3_q == 3'd1) | (funct3_q == 3'd2) | (is_div & ~funct3_q[0]);
      signed_b = (funct3_q == 3'd1) | (is_div & ~funct3_q[0]);
      mul_high = ~is_div & (funct3_q[1:0] != 2'b00);
      ext_a    = a_q;
      ext_b    = b_q;
    end
    mag_a = (signed_a & ext_a[63]) ? -ext_a : ext_a;
    mag_b = (signed_b & ext_b[63]) ? -ext_b : ext_b;
  end

  always_comb begin
    mul_sum   = {1'b0, acc_q[127:64]} + (acc_q[0] ? {1'b0, a_q} : 65'd0);
    div_shift = acc_q[127:63];
    div_diff  = div_shift - {1'b0, b_q};
    prod      = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
    quo       = (neg_a_q ^ neg_b_q) ? -acc_q[63:0] : acc_q[63:0];
    rem       = neg_a_q ? -acc_q[127:64] : acc_q[127:64];
    // Divide-by-zero remainder and signed overflow fall out of the datapath; only the quotient needs forcing
    if (!is_div)
      res = mul_high ? prod[127:64] : prod[63:0];
    else if (funct3_q[1])
      res = rem;
    else if (div_zero_q)
      res = '1;
    else
      res = quo;
    if (word_q)
      res = {{32{res[31]}}, res[31:0]};
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    funct3_d   = funct3_q;
    word_d     = word_q;
    rd_d       = rd_q;
    neg_a_d    = neg_a_q;
    neg_b_d    = neg_b_q;
    div_zero_d = div_zero_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    result_d   = result_q;
    rd_out_d   = rd_out_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d      = bus.rs1_data;
          b_d      = bus.rs2_data;
          funct3_d = bus.funct3;
          word_d   = word_in;
          rd_d     = bus.rd_address;
          busy_d   = 1'b1;
          state_d  = PREP;
        end
      end
      PREP: begin
        a_d        = mag_a;
        b_d        = mag_b;
        neg_a_d    = signed_a & ext_a[63];
        neg_b_d    = signed_b & ext_b[63];
        div_zero_d = (ext_b == 64'd0);
        acc_d      = {64'd0, is_div ? mag_a : mag_b};
        cnt_d      = 6'd0;
        state_d    = CALC;
      end
      CALC: begin
        // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
        if (is_div) begin
          if (!div_diff[64])
            acc_d = {div_diff[63:0], acc_q[62:0], 1'b1};
          else
            acc_d = {div_shift[63:0], acc_q[62:0], 1'b0};
        end else begin
          acc_d = {mul_sum, acc_q[63:1]};
        end
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd63)
          state_d = FIN;
      end
      FIN: begin
        result_d = res;
        rd_out_d = rd_q;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 6'd0;
      a_q        <= 64'd0;
      b_q        <= 64'd0;
      acc_q      <= 128'd0;
      funct3_q   <= 3'd0;
      word_q     <= 1'b0;
      rd_q       <= 5'd0;
      neg_a_q    <= 1'b0;
      neg_b_q    <= 1'b0;
      div_zero_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= 64'd0;
      rd_out_q   <= 5'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      funct3_q   <= funct3_d;
      word_q     <= word_d;
      rd_q       <= rd_d;
      neg_a_q    <= neg_a_d;
      neg_b_q    <= neg_b_d;
      div_zero_q <= div_zero_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      result_q   <= result_d;
      rd_out_q   <= rd_out_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.rd_out = rd_out_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random ops against an arithmetic model.
module tb_muldiv_unit;
  logic clock = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

`ifdef MULDIV_WORD_OPS_EN
  localparam bit WordEn = 1'b1;
`else
  localparam bit WordEn = 1'b0;
`endif

  localparam logic [63:0] Ones = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MinV = 64'h8000_0000_0000_0000;

  always #5 clock = ~clock;

  muldiv_unit_if bus ();
  muldiv_unit dut (.clock(clock), .reset(reset), .bus(bus));

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Reference: plain RISC-V M arithmetic on wide integers
  function automatic logic [63:0] refModel(input logic [2:0] f3, input logic w,
                                           input logic [63:0] a, input logic [63:0] b);
    logic [127:0]       p;
    logic signed [63:0] sa, sb, sq;
    logic signed [31:0] a32, b32, s32;
    logic [31:0]        r32;
    if (w) begin
      a32 = a[31:0];
      b32 = b[31:0];
      if (!f3[2]) begin
        r32 = a[31:0] * b[31:0];
      end else begin
        case (f3[1:0])
          2'd0: begin
            if (b32 == 0) r32 = 32'hFFFF_FFFF;
            else if (a32 == -32'sd2147483648 && b32 == -1) r32 = a[31:0];
            else begin s32 = a32 / b32; r32 = s32; end
          end
          2'd1: begin
            if (b[31:0] == 0) r32 = 32'hFFFF_FFFF;
            else r32 = a[31:0] / b[31:0];
          end
          2'd2: begin
            if (b32 == 0) r32 = a[31:0];
            else if (a32 == -32'sd2147483648 && b32 == -1) r32 = 32'd0;
            else begin s32 = a32 % b32; r32 = s32; end
          end
          default: begin
            if (b[31:0] == 0) r32 = a[31:0];
            else r32 = a[31:0] % b[31:0];
          end
        endcase
      end
      return {{32{r32[31]}}, r32};
    end
    sa = a;
    sb = b;
    case (f3)
      3'd0: begin p = {64'd0, a} * {64'd0, b}; return p[63:0]; end
      3'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; return p[127:64]; end
      3'd2: begin p = {{64{a[63]}}, a} * {64'd0, b}; return p[127:64]; end
      3'd3: begin p = {64'd0, a} * {64'd0, b}; return p[127:64]; end
      3'd4: begin
        if (b == 0) return Ones;
        if (a == MinV && b == Ones) return a;
        sq = sa / sb;
        return sq;
      end
      3'd5: begin
        if (b == 0) return Ones;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == MinV && b == Ones) return 64'd0;
        sq = sa % sb;
        return sq;
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic logic [63:0] pickOperand();
    case ($urandom_range(0, 5))
      0:       return 64'd0;
      1:       return Ones;
      2:       return MinV;
      3:       return 64'($urandom_range(0, 20));
      4:       return {$urandom, $urandom};
      default: return {$urandom, 32'h8000_0000};
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Launch one op, scramble the inputs after acceptance, and check latency, result and rd
  task automatic applyStimulus(input logic [2:0] f3, input logic w, input logic [63:0] a,
                               input logic [63:0] b, input logic [4:0] rd,
                               input int pulseAt, input string tag);
    int          cycles;
    int          guard;
    logic        sawDone;
    logic        busyOk;
    logic [63:0] exp;
    exp   = refModel(f3, w & WordEn, a, b);
    guard = 0;
    while (bus.busy === 1'b1 && guard < 200) begin
      @(posedge clock); #1;
      guard++;
    end
    bus.start      = 1'b1;
    bus.funct3     = f3;
    bus.op_word    = w;
    bus.rs1_data   = a;
    bus.rs2_data   = b;
    bus.rd_address = rd;
    @(posedge clock); #1;
    bus.start      = 1'b0;
    bus.funct3     = ~f3;
    bus.op_word    = ~w;
    bus.rs1_data   = {$urandom, $urandom};
    bus.rs2_data   = {$urandom, $urandom};
    bus.rd_address = ~rd;
    cycles  = 0;
    busyOk  = 1'b1;
    sawDone = 1'b0;
    while (!sawDone && cycles < 150) begin
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) busyOk = 1'b0;
      bus.start = (cycles == pulseAt);
      @(posedge clock); #1;
      cycles++;
      if (bus.done === 1'b1) sawDone = 1'b1;
    end
    bus.start = 1'b0;
    checkOutput({tag, " latency"}, 64'(cycles), 64'd66);
    checkOutput({tag, " busy-while-running"}, {63'd0, busyOk}, 64'd1);
    checkOutput({tag, " busy-at-done"}, {63'd0, bus.busy}, 64'd0);
    checkOutput({tag, " result"}, bus.result, exp);
    checkOutput({tag, " rd_out"}, {59'd0, bus.rd_out}, {59'd0, rd});
    @(posedge clock); #1;
    checkOutput({tag, " done-one-cycle"}, {63'd0, bus.done}, 64'd0);
    checkOutput({tag, " result-held"}, bus.result, exp);
  endtask

  initial begin
    int          cyc;
    int          dones;
    logic [63:0] exp1, exp2;

    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.funct3     = 3'd0;
    bus.op_word    = 1'b0;
    bus.rs1_data   = 64'd0;
    bus.rs2_data   = 64'd0;
    bus.rd_address = 5'd0;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset busy", {63'd0, bus.busy}, 64'd0);
    checkOutput("reset done", {63'd0, bus.done}, 64'd0);
    checkOutput("reset result", bus.result, 64'd0);
    checkOutput("reset rd_out", {59'd0, bus.rd_out}, 64'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    applyStimulus(3'd0, 1'b0, 64'd7, -64'sd3, 5'd5, -1, "MUL 7*-3");
    checkOutput("MUL 7*-3 literal", bus.result, 64'hFFFF_FFFF_FFFF_FFEB);
    applyStimulus(3'd3, 1'b0, Ones, Ones, 5'd9, -1, "MULHU ones");
    applyStimulus(3'd1, 1'b0, Ones, Ones, 5'd10, -1, "MULH ones");
    applyStimulus(3'd2, 1'b0, Ones, Ones, 5'd11, -1, "MULHSU ones");
    applyStimulus(3'd4, 1'b0, -64'sd7, 64'd2, 5'd12, -1, "DIV -7/2");
    checkOutput("DIV -7/2 literal", bus.result, -64'sd3);
    applyStimulus(3'd6, 1'b0, -64'sd7, 64'd2, 5'd13, -1, "REM -7%2");
    checkOutput("REM -7%2 literal", bus.result, Ones);
    applyStimulus(3'd5, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'd0, 5'd14, -1, "DIVU by zero");
    applyStimulus(3'd4, 1'b0, -64'sd5, 64'd0, 5'd15, -1, "DIV by zero");
    applyStimulus(3'd6, 1'b0, -64'sd5, 64'd0, 5'd16, -1, "REM by zero");
    applyStimulus(3'd7, 1'b0, 64'hDEAD_BEEF, 64'd0, 5'd17, -1, "REMU by zero");
    applyStimulus(3'd6, 1'b0, MinV, Ones, 5'd18, -1, "REM overflow");
    applyStimulus(3'd4, 1'b0, MinV, Ones, 5'd19, -1, "DIV overflow");
    applyStimulus(3'd5, 1'b0, Ones, 64'd3, 5'd0, 10, "DIVU start-pulse rd0");

`ifdef MULDIV_WORD_OPS_EN
    applyStimulus(3'd4, 1'b1, 64'h0000_0000_8000_0000, Ones, 5'd20, -1, "DIVW overflow");
    checkOutput("DIVW overflow literal", bus.result, 64'hFFFF_FFFF_8000_0000);
    applyStimulus(3'd0, 1'b1, 64'h1_0000_0003, 64'd2, 5'd21, -1, "MULW");
    checkOutput("MULW literal", bus.result, 64'd6);
    applyStimulus(3'd2, 1'b1, 64'hFFFF_FFFF_0000_0007, 64'd5, 5'd22, -1, "MULHSU as MULW");
    applyStimulus(3'd6, 1'b1, 64'h0000_0000_8000_0001, 64'd0, 5'd23, -1, "REMW by zero");
`endif

    // Back-to-back: start held through the first op and its done cycle
    exp1 = refModel(3'd5, 1'b0, 64'd1000, 64'd7);
    exp2 = refModel(3'd6, 1'b0, -64'sd1000, 64'd7);
    bus.start = 1'b1; bus.funct3 = 3'd5; bus.op_word = 1'b0;
    bus.rs1_data = 64'd1000; bus.rs2_data = 64'd7; bus.rd_address = 5'd3;
    @(posedge clock); #1;
    bus.funct3 = 3'd6; bus.rs1_data = -64'sd1000; bus.rd_address = 5'd4;
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 150) begin
      @(posedge clock); #1;
      cyc++;
    end
    checkOutput("b2b first latency", 64'(cyc), 64'd66);
    checkOutput("b2b first result", bus.result, exp1);
    checkOutput("b2b first rd_out", {59'd0, bus.rd_out}, 64'd3);
    @(posedge clock); #1;
    bus.start = 1'b0;
    cyc = 1;
    checkOutput("b2b second accepted", {63'd0, bus.busy}, 64'd1);
    while (bus.done !== 1'b1 && cyc < 150) begin
      @(posedge clock); #1;
      cyc++;
    end
    checkOutput("b2b done spacing", 64'(cyc), 64'd67);
    checkOutput("b2b second result", bus.result, exp2);
    checkOutput("b2b second rd_out", {59'd0, bus.rd_out}, 64'd4);
    @(posedge clock); #1;

    // Reset during iteration 30 of a divide
    applyStimulus(3'd0, 1'b0, 64'd7, -64'sd3, 5'd6, -1, "pre-reset MUL");
    bus.start = 1'b1; bus.funct3 = 3'd4;
    bus.rs1_data = 64'd123_456_789; bus.rs2_data = 64'd3; bus.rd_address = 5'd7;
    @(posedge clock); #1;
    bus.start = 1'b0;
    repeat (31) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    checkOutput("abort busy", {63'd0, bus.busy}, 64'd0);
    checkOutput("abort result", bus.result, 64'd0);
    checkOutput("abort rd_out", {59'd0, bus.rd_out}, 64'd0);
    reset = 1'b0;
    dones = 0;
    repeat (100) begin
      @(posedge clock); #1;
      if (bus.done === 1'b1) dones++;
    end
    checkOutput("abort no done", 64'(dones), 64'd0);

    for (int i = 0; i < 40; i++) begin
      applyStimulus(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), pickOperand(),
                    pickOperand(), 5'($urandom), -1, $sformatf("random %0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
